// File: rtl/frost32_irq_ctrl_if.sv
// frost32_irq_ctrl_if: request/dispatch bundle between peripherals, CPU and the interrupt controller
// master drives sources, mask, stall and clear; slave (the controller) drives interrupt, irq_id, pending, busy
interface frost32_irq_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int IDW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_mask;
  logic wait_for_mem;
  logic clr_valid;
  logic [IDW-1:0] clr_id;
  logic interrupt;
  logic [IDW-1:0] irq_id;
  logic [NUM_SRC-1:0] pending;
  logic busy;
  modport master (
    output irq_src, irq_mask, wait_for_mem, clr_valid, clr_id,
    input interrupt, irq_id, pending, busy
  );
  modport slave (
    input irq_src, irq_mask, wait_for_mem, clr_valid, clr_id,
    output interrupt, irq_id, pending, busy
  );
endinterface

// File: rtl/frost32_irq_ctrl.sv
// frost32_irq_ctrl: latches source rising edges and dispatches the lowest eligible one as a fixed pulse
// clk/rst_n plain ports; bus carries irq_src, irq_mask, wait_for_mem, clr_valid/clr_id in and
// interrupt, irq_id, pending, busy out
module frost32_irq_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int PULSE_CYCLES = 3,
  parameter int HOLDOFF_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  frost32_irq_ctrl_if.slave bus
);
  localparam int IDW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int MAXC = PULSE_CYCLES > HOLDOFF_CYCLES ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_SRC-1:0] src_q, pend, edges, elig, disp_vec, clr_vec;
  logic [IDW-1:0] id, low_id;
  logic dispatch;
  assign edges = bus.irq_src & ~src_q;
  assign elig = pend & bus.irq_mask;
  assign disp_vec = dispatch ? NUM_SRC'(1) << low_id : '0;
  // out-of-range clear ids are dropped rather than aliased onto a real source
  assign clr_vec = (bus.clr_valid && 32'(bus.clr_id) < NUM_SRC) ? NUM_SRC'(1) << bus.clr_id : '0;
  assign bus.interrupt = state == ASSERT;
  assign bus.busy = state != IDLE;
  assign bus.irq_id = id;
  assign bus.pending = pend;
  always_comb begin
    low_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) low_id = IDW'(i);
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dispatch = 1'b0;
    if (state == IDLE) begin
      dispatch = |elig && !bus.wait_for_mem;
      if (dispatch) begin
        state_n = ASSERT;
        cnt_n = CW'(PULSE_CYCLES - 1);
      end
    end else if (cnt == '0) begin
      state_n = state == ASSERT ? HOLDOFF : IDLE;
      cnt_n = state == ASSERT ? CW'(HOLDOFF_CYCLES - 1) : '0;
    end else begin
      cnt_n = cnt - CW'(1);
    end
  end
  // src_q resets high so lines already asserted at reset release do not register as edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      src_q <= '1;
      pend <= '0;
      id <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      src_q <= bus.irq_src;
      pend <= edges | (pend & ~disp_vec & ~clr_vec);
      if (dispatch) id <= low_id;
    end
  end
endmodule

// File: tb/tb_frost32_irq_ctrl.sv
// tb_frost32_irq_ctrl: directed and randomized checks against a timeline-based reference model
module tb_frost32_irq_ctrl;
  localparam int P = 3;
  localparam int H = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc, rise, hi, g;
  logic [3:0] m_pend, m_prev;
  logic [1:0] m_id;
  logic exp_int, exp_busy;
  frost32_irq_ctrl_if #(.NUM_SRC(4)) bus ();
  frost32_irq_ctrl #(.NUM_SRC(4), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_pend = '0;
    m_prev = '1;
    m_id = '0;
    rise = -1000;
    cyc = 0;
    exp_int = 1'b0;
    exp_busy = 1'b0;
  endtask
  // model: a dispatch at cycle r owns cycles r..r+P-1 (pulse) and r+P..r+P+H-1 (holdoff)
  task automatic m_tick();
    logic [3:0] e, d, c;
    e = bus.irq_src & ~m_prev;
    d = '0;
    c = bus.clr_valid ? 4'(1) << bus.clr_id : 4'(0);
    if (cyc >= rise + P + H + 1 && (m_pend & bus.irq_mask) != 0 && !bus.wait_for_mem) begin
      for (int j = 3; j >= 0; j--)
        if (m_pend[j] && bus.irq_mask[j]) m_id = 2'(j);
      d = 4'(1) << m_id;
      rise = cyc;
    end
    m_pend = e | (m_pend & ~d & ~c);
    m_prev = bus.irq_src;
    exp_int = cyc - rise < P;
    exp_busy = cyc - rise < P + H;
    cyc++;
  endtask
  task automatic step();
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_tick();
    @(negedge clk);
    chk("interrupt", 32'(bus.interrupt), 32'(exp_int));
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("irq_id", 32'(bus.irq_id), 32'(m_id));
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) step();
    chk("idle_timeout", 32'(bus.busy), 32'(0));
  endtask
  initial begin
    m_reset();
    bus.irq_src = 4'b0010;
    bus.irq_mask = 4'hF;
    bus.wait_for_mem = 1'b0;
    bus.clr_valid = 1'b0;
    bus.clr_id = '0;
    step();
    step();
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      hi += int'(bus.interrupt);
    end
    chk("rst_pending", 32'(bus.pending), 32'(0));
    chk("rst_no_irq", 32'(hi), 32'(0));
    bus.irq_src = 4'b0000;
    step();
    bus.irq_src = 4'b0100;
    step();
    chk("single_pend", 32'(bus.pending), 32'(4'b0100));
    chk("single_early", 32'(bus.interrupt), 32'(0));
    step();
    chk("single_rise", 32'(bus.interrupt), 32'(1));
    chk("single_id", 32'(bus.irq_id), 32'(2));
    hi = 0;
    for (int i = 0; i < 10 && bus.interrupt; i++) begin
      hi++;
      step();
    end
    chk("single_len", 32'(hi), 32'(P));
    chk("single_pend0", 32'(bus.pending), 32'(0));
    g = hi;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      g++;
      step();
    end
    chk("single_busy", 32'(g), 32'(P + H));
    bus.irq_src = 4'b0000;
    step();
    bus.irq_src = 4'b1010;
    step();
    step();
    chk("prio_id1", 32'(bus.irq_id), 32'(1));
    for (int i = 0; i < 10 && bus.interrupt; i++) step();
    g = 0;
    while (!bus.interrupt && g < 40) begin
      step();
      g++;
    end
    chk("prio_gap", 32'(g), 32'(H + 1));
    chk("prio_id3", 32'(bus.irq_id), 32'(3));
    wait_idle();
    bus.irq_src = 4'b0000;
    step();
    bus.wait_for_mem = 1'b1;
    bus.irq_src = 4'b0001;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hi += int'(bus.interrupt);
    end
    chk("stall_block", 32'(hi), 32'(0));
    bus.wait_for_mem = 1'b0;
    step();
    chk("stall_rise", 32'(bus.interrupt), 32'(1));
    bus.wait_for_mem = 1'b1;
    hi = 0;
    for (int i = 0; i < 10 && bus.interrupt; i++) begin
      hi++;
      step();
    end
    chk("stall_len", 32'(hi), 32'(P));
    bus.wait_for_mem = 1'b0;
    wait_idle();
    bus.irq_mask = 4'b1110;
    bus.irq_src = 4'b0000;
    step();
    bus.irq_src = 4'b0001;
    step();
    step();
    chk("mask_pend", 32'(bus.pending[0]), 32'(1));
    chk("mask_noirq", 32'(bus.interrupt), 32'(0));
    bus.clr_valid = 1'b1;
    bus.clr_id = 2'd0;
    step();
    bus.clr_valid = 1'b0;
    chk("clr_pend", 32'(bus.pending[0]), 32'(0));
    bus.irq_src = 4'b0000;
    step();
    bus.irq_src = 4'b0001;
    step();
    bus.irq_mask = 4'hF;
    step();
    chk("unmask_irq", 32'(bus.interrupt), 32'(1));
    chk("unmask_id", 32'(bus.irq_id), 32'(0));
    bus.irq_src = 4'b0101;
    bus.clr_valid = 1'b1;
    bus.clr_id = 2'd2;
    step();
    bus.clr_valid = 1'b0;
    chk("set_beats_clr", 32'(bus.pending[2]), 32'(1));
    wait_idle();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) bus.irq_src = bus.irq_src ^ 4'($urandom);
      if ($urandom_range(0, 40) == 0) bus.irq_mask = 4'($urandom);
      bus.wait_for_mem = $urandom_range(0, 3) == 0;
      bus.clr_valid = $urandom_range(0, 9) == 0;
      bus.clr_id = 2'($urandom);
      step();
    end
    bus.clr_valid = 1'b0;
    bus.wait_for_mem = 1'b0;
    bus.irq_mask = 4'hF;
    wait_idle();
    bus.irq_src = 4'b0000;
    step();
    bus.irq_src = 4'b1000;
    for (int i = 0; i < 10 && !bus.interrupt; i++) step();
    chk("async_pre", 32'(bus.interrupt), 32'(1));
    bus.irq_src = 4'b1100;
    step();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_int", 32'(bus.interrupt), 32'(0));
    chk("async_pend", 32'(bus.pending), 32'(0));
    chk("async_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
